axis_step_driver: RTL and testbench

Sits directly downstream of the circular-interpolation core. Consumes its per-axis one-cycle step-request pulses (X_acc/X_dec/Y_acc/Y_dec) and draw_overH. Converts them into timing-compliant STEP/DIR waveforms for two stepper drivers, buffering bursts in signed pending counters. Also tracks absolute axis positions and reports move completion.

---
 rtl/axis_step_driver_pkg.sv | 25 ++
 rtl/axis_step_driver_step_channel.sv | 125 ++++++++++++
 rtl/axis_step_driver.sv | 80 ++++++++
 tb/tb_axis_step_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_step_driver_pkg.sv
// Shared channel state encoding and default timing/width constants.
package axis_step_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIR_WAIT = 2'd1,
    ST_STEP_HI  = 2'd2,
    ST_STEP_LO  = 2'd3
  } chan_state_e;

  localparam int unsigned DEF_POS_W     = 16;
  localparam int unsigned DEF_PEND_W    = 8;
  localparam int unsigned DEF_DIR_SETUP = 2;
  localparam int unsigned DEF_STEP_HIGH = 3;
  localparam int unsigned DEF_STEP_LOW  = 3;

  // Largest of the three hold times, used to size the shared phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/axis_step_driver_step_channel.sv
// One axis: signed pending-step buffer, STEP/DIR sequencer and position counter.
module step_channel
  import axis_step_driver_pkg::*;
#(
  parameter int unsigned POS_W     = DEF_POS_W,
  parameter int unsigned PEND_W    = DEF_PEND_W,
  parameter int unsigned DIR_SETUP = DEF_DIR_SETUP,
  parameter int unsigned STEP_HIGH = DEF_STEP_HIGH,
  parameter int unsigned STEP_LOW  = DEF_STEP_LOW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_acc,
  input  logic             i_dec,
  input  logic             i_pos_clr,
  output logic             o_step,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pos,
  output logic             o_busy_c,
  output logic             o_ovf_c
);

  localparam int unsigned T_MAX = max3(DIR_SETUP, STEP_HIGH, STEP_LOW);
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic signed [PEND_W:0] P_MAX = (PEND_W+1)'((1 << (PEND_W-1)) - 1);

  chan_state_e              r_state, w_state_n;
  logic [CNT_W-1:0]         r_cnt, w_cnt_n;
  logic signed [PEND_W-1:0] r_pend, w_pend_n;
  logic [POS_W-1:0]         r_pos, w_pos_n;
  logic                     r_dir, w_dir_n;
  logic                     r_step;
  logic                     w_enter;
  logic signed [PEND_W:0]   w_pend_ext, w_req, w_adj, w_sum, w_keep;
  logic                     w_ovf;

  // Next-state sequencing, pending arithmetic and position update.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_dir_n   = r_dir;
    w_enter   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != '0) begin
          if ((~r_pend[PEND_W-1]) == r_dir) begin
            w_state_n = ST_STEP_HI;
            w_cnt_n   = CNT_W'(STEP_HIGH - 1);
            w_enter   = 1'b1;
          end else begin
            w_state_n = ST_DIR_WAIT;
            w_cnt_n   = CNT_W'(DIR_SETUP - 1);
            w_dir_n   = ~r_dir;
          end
        end
      end
      ST_DIR_WAIT: begin
        if (r_cnt == '0) begin
          w_state_n = ST_STEP_HI;
          w_cnt_n   = CNT_W'(STEP_HIGH - 1);
          w_enter   = 1'b1;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_STEP_HI: begin
        if (r_cnt == '0) begin
          w_state_n = ST_STEP_LO;
          w_cnt_n   = CNT_W'(STEP_LOW - 1);
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      ST_STEP_LO: begin
        if (r_cnt == '0) w_state_n = ST_IDLE;
        else             w_cnt_n   = r_cnt - CNT_W'(1);
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Request and step-consumption combine; a request that would leave range is dropped.
    w_pend_ext = {r_pend[PEND_W-1], r_pend};
    w_req      = '0;
    if (i_acc && !i_dec)      w_req = (PEND_W+1)'(1);
    else if (i_dec && !i_acc) w_req = '1;
    w_adj = '0;
    if (w_enter) w_adj = r_dir ? '1 : (PEND_W+1)'(1);
    w_keep   = w_pend_ext + w_adj;
    w_sum    = w_keep + w_req;
    w_ovf    = (w_req != '0) && ((w_sum > P_MAX) || (w_sum < -P_MAX));
    w_pend_n = w_ovf ? w_keep[PEND_W-1:0] : w_sum[PEND_W-1:0];

    // Clear wins over a step counted on the same edge.
    w_pos_n = r_pos;
    if (i_pos_clr)    w_pos_n = '0;
    else if (w_enter) w_pos_n = r_pos + (r_dir ? POS_W'(1) : '1);

    o_busy_c = (w_state_n != ST_IDLE) || (w_pend_n != '0);
    o_ovf_c  = w_ovf;
  end

  // Channel state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      r_pos   <= w_pos_n;
      r_dir   <= w_dir_n;
      r_step  <= (w_state_n == ST_STEP_HI);
    end
  end

  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_pos  = r_pos;

endmodule

// File: rtl/axis_step_driver.sv
// Two-axis STEP/DIR generator with move-completion and overflow reporting.
module axis_step_driver
  import axis_step_driver_pkg::*;
#(
  parameter int unsigned POS_W     = DEF_POS_W,
  parameter int unsigned PEND_W    = DEF_PEND_W,
  parameter int unsigned DIR_SETUP = DEF_DIR_SETUP,
  parameter int unsigned STEP_HIGH = DEF_STEP_HIGH,
  parameter int unsigned STEP_LOW  = DEF_STEP_LOW
) (
  input  logic             pulse_clk,
  input  logic             sys_rst_h,
  input  logic             X_acc,
  input  logic             X_dec,
  input  logic             Y_acc,
  input  logic             Y_dec,
  input  logic             draw_overH,
  input  logic             pos_clrH,
  output logic             X_step,
  output logic             X_dir,
  output logic             Y_step,
  output logic             Y_dir,
  output logic [POS_W-1:0] X_pos,
  output logic [POS_W-1:0] Y_pos,
  output logic             busyH,
  output logic             move_doneH,
  output logic             ovf_errH
);

  logic w_x_busy_c, w_y_busy_c, w_x_ovf_c, w_y_ovf_c;
  logic w_busy_n, w_done_n, w_latch_n;
  logic r_latch, r_draw_q, r_busy, r_done, r_ovf;

  step_channel #(
    .POS_W(POS_W), .PEND_W(PEND_W), .DIR_SETUP(DIR_SETUP),
    .STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW)
  ) u_x (
    .i_clk(pulse_clk), .i_rst(sys_rst_h), .i_acc(X_acc), .i_dec(X_dec),
    .i_pos_clr(pos_clrH), .o_step(X_step), .o_dir(X_dir), .o_pos(X_pos),
    .o_busy_c(w_x_busy_c), .o_ovf_c(w_x_ovf_c)
  );

  step_channel #(
    .POS_W(POS_W), .PEND_W(PEND_W), .DIR_SETUP(DIR_SETUP),
    .STEP_HIGH(STEP_HIGH), .STEP_LOW(STEP_LOW)
  ) u_y (
    .i_clk(pulse_clk), .i_rst(sys_rst_h), .i_acc(Y_acc), .i_dec(Y_dec),
    .i_pos_clr(pos_clrH), .o_step(Y_step), .o_dir(Y_dir), .o_pos(Y_pos),
    .o_busy_c(w_y_busy_c), .o_ovf_c(w_y_ovf_c)
  );

  // Completion: latch a draw_overH rise, fire once both channels are drained and idle.
  always_comb begin
    w_busy_n  = w_x_busy_c | w_y_busy_c;
    w_done_n  = r_latch & ~w_busy_n;
    w_latch_n = (r_latch & ~w_done_n) | (draw_overH & ~r_draw_q);
  end

  // Status registers.
  always_ff @(posedge pulse_clk) begin
    if (sys_rst_h) begin
      r_latch  <= 1'b0;
      r_draw_q <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_latch  <= w_latch_n;
      r_draw_q <= draw_overH;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_ovf    <= r_ovf | w_x_ovf_c | w_y_ovf_c;
    end
  end

  assign busyH      = r_busy;
  assign move_doneH = r_done;
  assign ovf_errH   = r_ovf;

endmodule

// File: tb/tb_axis_step_driver.sv
// Directed bench for axis_step_driver with default parameters.
module tb_axis_step_driver;

  logic        pulse_clk = 1'b0;
  logic        sys_rst_h, X_acc, X_dec, Y_acc, Y_dec, draw_overH, pos_clrH;
  logic        X_step, X_dir, Y_step, Y_dir, busyH, move_doneH, ovf_errH;
  logic [15:0] X_pos, Y_pos;

  int vecs = 0;
  int errs = 0;

  axis_step_driver dut (
    .pulse_clk(pulse_clk), .sys_rst_h(sys_rst_h),
    .X_acc(X_acc), .X_dec(X_dec), .Y_acc(Y_acc), .Y_dec(Y_dec),
    .draw_overH(draw_overH), .pos_clrH(pos_clrH),
    .X_step(X_step), .X_dir(X_dir), .Y_step(Y_step), .Y_dir(Y_dir),
    .X_pos(X_pos), .Y_pos(Y_pos), .busyH(busyH), .move_doneH(move_doneH),
    .ovf_errH(ovf_errH)
  );

  always #5 pulse_clk = ~pulse_clk;

  task automatic tick();
    @(posedge pulse_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_h = 1'b1;
    tick();
    sys_rst_h = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({X_step, X_dir, Y_step, Y_dir, busyH, move_doneH, ovf_errH} !== 7'b0101000) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 0101000",
               {X_step, X_dir, Y_step, Y_dir, busyH, move_doneH, ovf_errH});
    end
    vecs++;
    if ({X_pos, Y_pos} !== 32'h0) begin
      errs++;
      $display("FAIL reset_pos: got %h/%h want 0/0", X_pos, Y_pos);
    end
  endtask

  // X_acc in cycle 5: STEP high 7..9, busy 6..12.
  task automatic test_single_x();
    logic [3:0] exp;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      exp = {(c >= 7 && c <= 9), 1'b1, (c >= 6 && c <= 12), 1'b0};
      vecs++;
      if ({X_step, X_dir, busyH, Y_step} !== exp) begin
        errs++;
        $display("FAIL single_x c=%0d: step/dir/busy/ystep got %b want %b",
                 c, {X_step, X_dir, busyH, Y_step}, exp);
      end
      X_acc = (c == 5);
      tick();
    end
    vecs++;
    if ($signed(X_pos) !== 16'sd1 || Y_pos !== 16'd0) begin
      errs++;
      $display("FAIL single_x_pos: got %0d/%0d want 1/0", $signed(X_pos), $signed(Y_pos));
    end
  endtask

  // X_dec in cycle 5: DIR falls at 7, STEP high 9..11, pos -1 from 9.
  task automatic test_dir_flip();
    logic [1:0] exp;
    int         ep;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      exp = {(c >= 9 && c <= 11), (c < 7)};
      ep  = (c >= 9) ? -1 : 0;
      vecs++;
      if ({X_step, X_dir} !== exp || $signed(X_pos) != ep) begin
        errs++;
        $display("FAIL dir_flip c=%0d: step/dir got %b pos %0d want %b pos %0d",
                 c, {X_step, X_dir}, $signed(X_pos), exp, ep);
      end
      X_dec = (c == 5);
      tick();
    end
  endtask

  // Clear alone, then clear on the edge that enters STEP_HI.
  task automatic test_pos_clr();
    pos_clrH = 1'b1;
    tick();
    pos_clrH = 1'b0;
    vecs++;
    if (X_pos !== 16'd0) begin
      errs++;
      $display("FAIL pos_clr: got %0d want 0", $signed(X_pos));
    end
    X_dec = 1'b1;
    tick();
    X_dec = 1'b0;
    pos_clrH = 1'b1;
    tick();
    pos_clrH = 1'b0;
    vecs++;
    if (X_step !== 1'b1 || X_pos !== 16'd0) begin
      errs++;
      $display("FAIL pos_clr_coincident: step %b pos %0d want 1 pos 0", X_step, $signed(X_pos));
    end
    for (int i = 0; i < 10; i++) tick();
    vecs++;
    if (X_pos !== 16'd0 || busyH !== 1'b0) begin
      errs++;
      $display("FAIL pos_clr_after: pos %0d busy %b want 0/0", $signed(X_pos), busyH);
    end
  endtask

  // Ten back-to-back Y_acc pulses.
  task automatic test_burst();
    int rises = 0, hi = 0, lo = 0, bad = 0, xs = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      Y_acc = (i < 10);
      if (Y_step && !prev) begin
        rises++;
        if (rises > 1 && lo < 3) bad++;
        hi = 0;
      end
      if (!Y_step && prev) begin
        if (hi != 3) bad++;
        lo = 0;
      end
      if (Y_step) hi++; else lo++;
      if (X_step) xs++;
      prev = Y_step;
      if (i > 12 && !busyH) break;
      tick();
    end
    Y_acc = 1'b0;
    vecs++;
    if (rises != 10 || bad != 0 || xs != 0) begin
      errs++;
      $display("FAIL burst_pulses: rises %0d bad %0d xsteps %0d want 10/0/0", rises, bad, xs);
    end
    vecs++;
    if ($signed(Y_pos) != 10 || ovf_errH !== 1'b0 || busyH !== 1'b0) begin
      errs++;
      $display("FAIL burst_end: pos %0d ovf %b busy %b want 10/0/0",
               $signed(Y_pos), ovf_errH, busyH);
    end
  endtask

  // Simultaneous acc and dec cancel.
  task automatic test_cancel();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      X_acc = (c < 4);
      X_dec = (c < 4);
      tick();
      vecs++;
      if ({X_step, busyH} !== 2'b00 || X_pos !== 16'd0) begin
        errs++;
        $display("FAIL cancel c=%0d: step/busy %b pos %0d want 00/0",
                 c, {X_step, busyH}, $signed(X_pos));
      end
    end
    X_acc = 1'b0;
    X_dec = 1'b0;
  endtask

  // Short arc: 3x (X_dec + Y_acc) then draw_overH; one done pulse STEP_LOW after last fall.
  task automatic test_arc();
    int   dones = 0, done_c = -1, last_fall = -1;
    logic px = 1'b0, py = 1'b0, busy_at_done = 1'b1;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      X_dec = (i < 12) && (i % 4 == 0);
      Y_acc = (i < 12) && (i % 4 == 0);
      draw_overH = (i == 12);
      if ((px && !X_step) || (py && !Y_step)) last_fall = i;
      if (move_doneH) begin
        dones++;
        done_c = i;
        busy_at_done = busyH;
      end
      px = X_step;
      py = Y_step;
      tick();
    end
    vecs++;
    if (dones != 1 || busy_at_done !== 1'b0) begin
      errs++;
      $display("FAIL arc_done_count: got %0d busy %b want 1/0", dones, busy_at_done);
    end
    vecs++;
    if (done_c - last_fall != 3) begin
      errs++;
      $display("FAIL arc_done_timing: done-lastfall %0d want 3", done_c - last_fall);
    end
    vecs++;
    if ($signed(X_pos) != -3 || $signed(Y_pos) != 3) begin
      errs++;
      $display("FAIL arc_pos: got %0d/%0d want -3/3", $signed(X_pos), $signed(Y_pos));
    end
  endtask

  // 200 back-to-back X_acc saturate the pending counter.
  task automatic test_overflow();
    int   rises = 0, n = 0;
    logic prev = 1'b0;
    do_reset();
    vecs++;
    if (ovf_errH !== 1'b0) begin
      errs++;
      $display("FAIL ovf_initial: got %b want 0", ovf_errH);
    end
    for (int i = 0; i < 3000; i++) begin
      X_acc = (i < 200);
      if (X_step && !prev) rises++;
      prev = X_step;
      n = i;
      if (i > 200 && !busyH) break;
      tick();
    end
    X_acc = 1'b0;
    vecs++;
    if (n >= 2999) begin
      errs++;
      $display("FAIL ovf_drain_timeout: busy %b still high", busyH);
    end
    vecs++;
    if (ovf_errH !== 1'b1) begin
      errs++;
      $display("FAIL ovf_sticky: got %b want 1", ovf_errH);
    end
    vecs++;
    if ($signed(X_pos) != rises || $signed(X_pos) >= 200 || $signed(X_pos) < 127) begin
      errs++;
      $display("FAIL ovf_pos: pos %0d pulses %0d want pos==pulses in [127,200)",
               $signed(X_pos), rises);
    end
  endtask

  // Reset while X is in STEP_HI and Y is waiting on a direction change.
  task automatic test_reset_mid();
    int seen = 0;
    X_acc = 1'b1;
    Y_dec = 1'b1;
    tick();
    X_acc = 1'b0;
    Y_dec = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (X_step) begin
        seen = 1;
        break;
      end
      tick();
    end
    vecs++;
    if (seen == 0 || Y_dir !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_setup: xstep seen %0d ydir %b want 1/0", seen, Y_dir);
    end
    do_reset();
    vecs++;
    if ({X_step, X_dir, Y_step, Y_dir, busyH, move_doneH, ovf_errH} !== 7'b0101000 ||
        {X_pos, Y_pos} !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid: ctrl %b pos %0d/%0d want 0101000 0/0",
               {X_step, X_dir, Y_step, Y_dir, busyH, move_doneH, ovf_errH},
               $signed(X_pos), $signed(Y_pos));
    end
    for (int i = 0; i < 10; i++) tick();
    vecs++;
    if ({X_step, Y_step, busyH} !== 3'b000) begin
      errs++;
      $display("FAIL reset_mid_discard: step/step/busy %b want 000", {X_step, Y_step, busyH});
    end
  endtask

  initial begin
    sys_rst_h = 1'b1;
    X_acc = 1'b0; X_dec = 1'b0; Y_acc = 1'b0; Y_dec = 1'b0;
    draw_overH = 1'b0; pos_clrH = 1'b0;
    tick();
    test_reset();
    test_single_x();
    test_dir_flip();
    test_pos_clr();
    test_burst();
    test_cancel();
    test_arc();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
